// File: rtl/jk_excitation_sequencer.sv
// jk_excitation_sequencer
//   Drives a bank of external JK flip-flops so that the bank moves to a
//   requested target state. Keeps a shadow copy of the bank state, derives
//   J/K per bit from the excitation table, strobes the bank once, waits
//   SETTLE cycles and then checks the read-back Q outputs against the shadow.
//   A mismatch raises a sticky error, bumps a saturating counter and
//   resynchronises the shadow to what the bank actually holds.
//
// Ports
//   CLK, RST_N   clock, asynchronous active-low reset
//   TGT          requested next bank state, qualified by TGT_VALID
//   TGT_READY    high only while idle; accept = TGT_VALID & TGT_READY
//   Q_FB         Q outputs read back from the bank
//   ERR_CLR      synchronous clear of ERR / MISCNT
//   J, K, JK_EN  registered drive, valid for the single strobe cycle
//   SHADOW       modelled bank state
//   ERR, MISCNT  sticky mismatch flag, saturating mismatch count
module jk_excitation_sequencer #(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       SETTLE    = 2,
   parameter logic              XFILL     = 1'b0,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] TGT,
   input  logic             TGT_VALID,
   output logic             TGT_READY,
   input  logic [WIDTH-1:0] Q_FB,
   input  logic             ERR_CLR,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             JK_EN,
   output logic [WIDTH-1:0] SHADOW,
   output logic             ERR,
   output logic [7:0]       MISCNT
);

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;

   // Last WAIT count value; unused when SETTLE is 0 because WAIT is skipped.
   localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   state_t           state, state_nxt;
   logic [3:0]       wait_cnt;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] j_nxt, k_nxt;
   logic             accept, mismatch;

   assign TGT_READY = (state == IDLE);
   assign accept    = TGT_READY & TGT_VALID;
   assign mismatch  = (state == CHECK) && (Q_FB != SHADOW);

   // Excitation table: a bit currently 0 only needs J (K free), a bit
   // currently 1 only needs K (J free); free inputs take XFILL.
   assign j_nxt = (~SHADOW & TGT)  | (SHADOW  & {WIDTH{XFILL}});
   assign k_nxt = (SHADOW  & ~TGT) | (~SHADOW & {WIDTH{XFILL}});

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (TGT_VALID) state_nxt = DRIVE;
         DRIVE:   state_nxt = (SETTLE == 0) ? CHECK : WAIT;
         WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
      else wait_cnt <= '0;
   end

   // J/K/JK_EN are loaded on accept so they are valid exactly during DRIVE,
   // and fall back to zero on the following edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tgt_q <= RESET_VAL;
         J     <= '0;
         K     <= '0;
         JK_EN <= 1'b0;
      end else begin
         J     <= '0;
         K     <= '0;
         JK_EN <= 1'b0;
         if (accept) begin
            tgt_q <= TGT;
            J     <= j_nxt;
            K     <= k_nxt;
            JK_EN <= 1'b1;
         end
      end
   end

   // A mismatch outranks ERR_CLR: the clear is applied first, then the new
   // mismatch is recorded, leaving ERR=1 and MISCNT=1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SHADOW <= RESET_VAL;
         ERR    <= 1'b0;
         MISCNT <= '0;
      end else begin
         if (state == DRIVE) SHADOW <= tgt_q;
         if (mismatch) begin
            SHADOW <= Q_FB;
            ERR    <= 1'b1;
            if (ERR_CLR)               MISCNT <= 8'd1;
            else if (MISCNT != 8'hFF)  MISCNT <= MISCNT + 8'd1;
         end else if (ERR_CLR) begin
            ERR    <= 1'b0;
            MISCNT <= '0;
         end
      end
   end

endmodule
